branch_reservation_station: RTL and testbench
=============================================

BRANCH_RESERVATION_STATION -- requirements
Module: branch_reservation_station

Interface
REQ-001 Parameter DEPTH, default 4, number of entries; DEPTH SHALL be in 2..8.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 flush  input  1  synchronous squash of all held and issuing branches.
REQ-005 disp_valid  input  1  dispatch request.
REQ-006 disp_ready  output  1  station can accept a dispatch this cycle.
REQ-007 disp_opcode  input  4  branch opcode: 1000 jz, 1001 jnz, 1010 js, 1011 jns.
REQ-008 disp_rob  input  4  ROB index of the branch.
REQ-009 disp_t_rdy, disp_a_rdy  input  1 each  target/condition operand already holds a value.
REQ-010 disp_t_tag, disp_a_tag  input  4 each  producer ROB tag when the operand is not ready.
REQ-011 disp_t_val, disp_a_val  input  16 each  operand value when ready.
REQ-012 cdb_valid  input  1; cdb_tag  input  4; cdb_value  input  16  result broadcast.
REQ-013 issue_valid  output  1  registered; one branch is presented to the branch unit.
REQ-014 issue_opcode  output  4; issue_rob  output  4; issue_vt  output  16; issue_va  output  16  registered issue payload.
REQ-015 No backpressure from the branch unit: every issue_valid pulse SHALL be consumed in that cycle.

Function
REQ-016 Entries SHALL be kept in age order: slot 0 is the oldest.
REQ-017 Each entry SHALL hold: valid, opcode, rob, and for t and a: rdy, tag, val.
REQ-018 count is the number of valid entries; disp_ready SHALL equal (count < DEPTH), computed from current state only.
REQ-019 Dispatch SHALL occur when disp_valid && disp_ready && !flush; the branch is written after all surviving entries.
REQ-020 Wakeup: on cdb_valid, every valid entry operand with rdy=0 and tag==cdb_tag SHALL set rdy=1 and val=cdb_value at the edge.
REQ-021 Bypass: a dispatching operand with rdy=0 and tag==cdb_tag while cdb_valid SHALL be stored with rdy=1 and val=cdb_value.
REQ-022 Entry ready = valid && t.rdy && a.rdy, evaluated on state before the edge; same-edge wakeups SHALL NOT make an entry issuable until the next cycle.
REQ-023 Select: each cycle, the lowest-index ready entry SHALL be chosen; ready entries SHALL NOT be blocked by older non-ready entries.
REQ-024 At the edge, the chosen entry's opcode, rob, t.val and a.val SHALL be loaded into the issue registers, and issue_valid SHALL be set to 1.
REQ-025 At the same edge, the chosen entry SHALL be removed and all younger entries SHALL shift down one slot, keeping age order.
REQ-026 With no ready entry, issue_valid SHALL be 0 next cycle; the payload registers SHALL hold their values.
REQ-027 Simultaneous issue and dispatch: both SHALL occur and count SHALL be unchanged; the new entry is written after the compacted survivors.
REQ-028 When count == DEPTH, disp_ready SHALL be 0 even if an issue occurs in that cycle.
REQ-029 Minimum latency: a dispatch with both operands ready at edge N SHALL produce issue_valid=1 after edge N+1.
REQ-030 At most one issue per cycle; at most one dispatch per cycle.
REQ-031 Opcodes outside 1000..1011 SHALL be stored and issued unchanged; the station does not decode opcodes.
REQ-032 Flush SHALL take priority over dispatch, wakeup and issue: at the edge, all valid bits and issue_valid SHALL be cleared, and that cycle's dispatch SHALL be dropped.

Reset
REQ-033 reset SHALL asynchronously clear all entry valid bits and issue_valid, and zero issue_opcode, issue_rob, issue_vt and issue_va; disp_ready SHALL read 1 during and after reset.
REQ-034 Reset asserted mid-operation SHALL discard all held branches; no issue_valid SHALL appear until a new dispatch is accepted after reset is released.

Verification
REQ-035 Dispatch jz rob=3, t=0x0040 ready, a=0x0000 ready at edge 1 -> after edge 2: issue_valid=1, opcode=1000, rob=3, vt=0x0040, va=0; then issue_valid=0.
REQ-036 Dispatch rob=5 with a waiting on tag 7, then rob=6 fully ready; CDB tag7=0x0001 two cycles later -> rob=6 issues first, and rob=5 issues with va=0x0001 one cycle after the CDB edge.
REQ-037 Dispatch with a waiting on tag 2 in the same cycle as CDB tag2=0x8000 -> bypass captures the value, and the branch issues after the next edge with va=0x8000.
REQ-038 Fill 4 entries, all non-ready -> disp_ready=0; a 5th disp_valid is ignored; a CDB wakeup of slot 1 -> slot 1 issues, count drops to 3, and disp_ready returns to 1.
REQ-039 Three held entries, with flush asserted in the same cycle as a dispatch and a ready entry -> next cycle count=0, issue_valid=0, and nothing issues afterwards.
REQ-040 Assert reset while two entries are held and issue_valid=1 -> outputs are cleared immediately without a clock edge, and no stale issue appears after reset is released.

Source files
------------

// File: rtl/branch_reservation_station.sv
// branch_reservation_station: age-ordered branch reservation station with CDB wakeup,
// same-cycle dispatch bypass and oldest-ready-first issue.
module branch_reservation_station #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        disp_valid,
    output logic        disp_ready,
    input  logic [3:0]  disp_opcode,
    input  logic [3:0]  disp_rob,
    input  logic        disp_t_rdy,
    input  logic        disp_a_rdy,
    input  logic [3:0]  disp_t_tag,
    input  logic [3:0]  disp_a_tag,
    input  logic [15:0] disp_t_val,
    input  logic [15:0] disp_a_val,
    input  logic        cdb_valid,
    input  logic [3:0]  cdb_tag,
    input  logic [15:0] cdb_value,
    output logic        issue_valid,
    output logic [3:0]  issue_opcode,
    output logic [3:0]  issue_rob,
    output logic [15:0] issue_vt,
    output logic [15:0] issue_va
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic        valid;
        logic [3:0]  opcode;
        logic [3:0]  rob;
        logic        t_rdy;
        logic [3:0]  t_tag;
        logic [15:0] t_val;
        logic        a_rdy;
        logic [3:0]  a_tag;
        logic [15:0] a_val;
    } entry_t;

    entry_t        ent_q [DEPTH];
    entry_t        ent_d [DEPTH];
    entry_t        woke  [DEPTH+1];
    entry_t        new_ent;
    entry_t        pick;
    logic [CW-1:0] count;
    logic [CW-1:0] sel;
    logic [CW-1:0] wr_idx;
    logic          found;
    logic          disp_fire;
    logic          issue_valid_q, issue_valid_d;
    logic [3:0]    issue_opcode_q, issue_opcode_d;
    logic [3:0]    issue_rob_q, issue_rob_d;
    logic [15:0]   issue_vt_q, issue_vt_d;
    logic [15:0]   issue_va_q, issue_va_d;

    assign disp_ready   = count < CW'(DEPTH);
    assign issue_valid  = issue_valid_q;
    assign issue_opcode = issue_opcode_q;
    assign issue_rob    = issue_rob_q;
    assign issue_vt     = issue_vt_q;
    assign issue_va     = issue_va_q;

    always_comb begin
        count = '0;
        found = 1'b0;
        sel   = '0;
        pick  = '0;
        // Descending scan so the last hit is the oldest ready entry.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            count = count + CW'(ent_q[i].valid);
            if (ent_q[i].valid && ent_q[i].t_rdy && ent_q[i].a_rdy) begin
                found = 1'b1;
                sel   = CW'(i);
                pick  = ent_q[i];
            end
        end
        woke[DEPTH] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = ent_q[i];
            if (cdb_valid && ent_q[i].valid && !ent_q[i].t_rdy && ent_q[i].t_tag == cdb_tag) begin
                woke[i].t_rdy = 1'b1;
                woke[i].t_val = cdb_value;
            end
            if (cdb_valid && ent_q[i].valid && !ent_q[i].a_rdy && ent_q[i].a_tag == cdb_tag) begin
                woke[i].a_rdy = 1'b1;
                woke[i].a_val = cdb_value;
            end
        end
        new_ent.valid  = 1'b1;
        new_ent.opcode = disp_opcode;
        new_ent.rob    = disp_rob;
        new_ent.t_tag  = disp_t_tag;
        new_ent.a_tag  = disp_a_tag;
        new_ent.t_rdy  = disp_t_rdy || (cdb_valid && disp_t_tag == cdb_tag);
        new_ent.a_rdy  = disp_a_rdy || (cdb_valid && disp_a_tag == cdb_tag);
        new_ent.t_val  = disp_t_rdy ? disp_t_val : cdb_value;
        new_ent.a_val  = disp_a_rdy ? disp_a_val : cdb_value;
        disp_fire = disp_valid && disp_ready && !flush;
        wr_idx    = count - CW'(found);
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = (found && CW'(i) >= sel) ? woke[i+1] : woke[i];
            if (flush)
                ent_d[i] = '0;
            else if (disp_fire && wr_idx == CW'(i))
                ent_d[i] = new_ent;
        end
        issue_valid_d  = found && !flush;
        issue_opcode_d = issue_valid_d ? pick.opcode : issue_opcode_q;
        issue_rob_d    = issue_valid_d ? pick.rob    : issue_rob_q;
        issue_vt_d     = issue_valid_d ? pick.t_val  : issue_vt_q;
        issue_va_d     = issue_valid_d ? pick.a_val  : issue_va_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                ent_q[i] <= '0;
            issue_valid_q  <= 1'b0;
            issue_opcode_q <= '0;
            issue_rob_q    <= '0;
            issue_vt_q     <= '0;
            issue_va_q     <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                ent_q[i] <= ent_d[i];
            issue_valid_q  <= issue_valid_d;
            issue_opcode_q <= issue_opcode_d;
            issue_rob_q    <= issue_rob_d;
            issue_vt_q     <= issue_vt_d;
            issue_va_q     <= issue_va_d;
        end
    end
endmodule

// File: tb/tb_branch_reservation_station.sv
// tb_branch_reservation_station: directed scenarios plus random traffic, checked against
// a queue-based reference model of the station.
module tb_branch_reservation_station;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        disp_valid = 1'b0;
    logic        disp_ready;
    logic [3:0]  disp_opcode = '0;
    logic [3:0]  disp_rob = '0;
    logic        disp_t_rdy = 1'b0;
    logic        disp_a_rdy = 1'b0;
    logic [3:0]  disp_t_tag = '0;
    logic [3:0]  disp_a_tag = '0;
    logic [15:0] disp_t_val = '0;
    logic [15:0] disp_a_val = '0;
    logic        cdb_valid = 1'b0;
    logic [3:0]  cdb_tag = '0;
    logic [15:0] cdb_value = '0;
    logic        issue_valid;
    logic [3:0]  issue_opcode;
    logic [3:0]  issue_rob;
    logic [15:0] issue_vt;
    logic [15:0] issue_va;

    branch_reservation_station #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_opcode(disp_opcode), .disp_rob(disp_rob),
        .disp_t_rdy(disp_t_rdy), .disp_a_rdy(disp_a_rdy),
        .disp_t_tag(disp_t_tag), .disp_a_tag(disp_a_tag),
        .disp_t_val(disp_t_val), .disp_a_val(disp_a_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .issue_valid(issue_valid), .issue_opcode(issue_opcode), .issue_rob(issue_rob),
        .issue_vt(issue_vt), .issue_va(issue_va)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  opc;
        logic [3:0]  rob;
        logic        tr;
        logic [3:0]  tt;
        logic [15:0] tv;
        logic        ar;
        logic [3:0]  at;
        logic [15:0] av;
    } br_t;

    br_t         q[$];
    logic        m_iv = 1'b0;
    logic [3:0]  m_io = '0;
    logic [3:0]  m_ir = '0;
    logic [15:0] m_vt = '0;
    logic [15:0] m_va = '0;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_iv = 1'b0; m_io = '0; m_ir = '0; m_vt = '0; m_va = '0;
    endtask

    // Oldest ready branch leaves, then the CDB wakes waiters, then the new branch joins the tail.
    task automatic model_edge();
        int pick = -1;
        bit accept;
        br_t n;
        if (flush) begin
            q.delete();
            m_iv = 1'b0;
            return;
        end
        accept = disp_valid && (q.size() < DEPTH);
        foreach (q[i]) if (pick < 0 && q[i].tr && q[i].ar) pick = i;
        m_iv = (pick >= 0);
        if (pick >= 0) begin
            m_io = q[pick].opc; m_ir = q[pick].rob; m_vt = q[pick].tv; m_va = q[pick].av;
            q.delete(pick);
        end
        if (cdb_valid) foreach (q[i]) begin
            if (!q[i].tr && q[i].tt == cdb_tag) begin q[i].tr = 1'b1; q[i].tv = cdb_value; end
            if (!q[i].ar && q[i].at == cdb_tag) begin q[i].ar = 1'b1; q[i].av = cdb_value; end
        end
        if (accept) begin
            n.opc = disp_opcode; n.rob = disp_rob; n.tt = disp_t_tag; n.at = disp_a_tag;
            n.tr = disp_t_rdy; n.tv = disp_t_val; n.ar = disp_a_rdy; n.av = disp_a_val;
            if (!n.tr && cdb_valid && n.tt == cdb_tag) begin n.tr = 1'b1; n.tv = cdb_value; end
            if (!n.ar && cdb_valid && n.at == cdb_tag) begin n.ar = 1'b1; n.av = cdb_value; end
            q.push_back(n);
        end
    endtask

    task automatic check_all();
        chk("disp_ready", {15'd0, disp_ready}, {15'd0, q.size() < DEPTH});
        chk("issue_valid", {15'd0, issue_valid}, {15'd0, m_iv});
        chk("issue_opcode", {12'd0, issue_opcode}, {12'd0, m_io});
        chk("issue_rob", {12'd0, issue_rob}, {12'd0, m_ir});
        chk("issue_vt", issue_vt, m_vt);
        chk("issue_va", issue_va, m_va);
    endtask

    task automatic idle_inputs();
        disp_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
        idle_inputs();
    endtask

    task automatic disp(input logic [3:0] opc, input logic [3:0] rob,
                        input logic tr, input logic [3:0] tt, input logic [15:0] tv,
                        input logic ar, input logic [3:0] at, input logic [15:0] av);
        disp_valid = 1'b1; disp_opcode = opc; disp_rob = rob;
        disp_t_rdy = tr; disp_t_tag = tt; disp_t_val = tv;
        disp_a_rdy = ar; disp_a_tag = at; disp_a_val = av;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [15:0] val);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val;
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_disp_ready", {15'd0, disp_ready}, 16'd1);
        chk("rst_issue_valid", {15'd0, issue_valid}, 16'd0);
        chk("rst_issue_rob", {12'd0, issue_rob}, 16'd0);
        chk("rst_issue_va", issue_va, 16'd0);
        @(posedge clk); #1; reset = 1'b0;
        check_all();

        // Minimum latency: ready at dispatch, issue after the following edge.
        disp(4'b1000, 4'd3, 1'b1, 4'd0, 16'h0040, 1'b1, 4'd0, 16'h0000); cyc();
        chk("lat_not_yet", {15'd0, issue_valid}, 16'd0);
        cyc();
        chk("lat_valid", {15'd0, issue_valid}, 16'd1);
        chk("lat_opcode", {12'd0, issue_opcode}, 16'h8);
        chk("lat_rob", {12'd0, issue_rob}, 16'd3);
        chk("lat_vt", issue_vt, 16'h0040);
        cyc();
        chk("lat_drop", {15'd0, issue_valid}, 16'd0);

        // Younger ready branch bypasses an older waiting one.
        disp(4'b1001, 4'd5, 1'b1, 4'd0, 16'h0010, 1'b0, 4'd7, 16'h0000); cyc();
        disp(4'b1010, 4'd6, 1'b1, 4'd0, 16'h0020, 1'b1, 4'd0, 16'h0030); cyc();
        cyc();
        chk("ooo_first_rob", {12'd0, issue_rob}, 16'd6);
        cdb(4'd7, 16'h0001); cyc();
        chk("ooo_wake_no_issue", {15'd0, issue_valid}, 16'd0);
        cyc();
        chk("ooo_second_rob", {12'd0, issue_rob}, 16'd5);
        chk("ooo_second_va", issue_va, 16'h0001);
        cyc();

        // Dispatch-cycle CDB bypass.
        disp(4'b1011, 4'd9, 1'b1, 4'd0, 16'h1234, 1'b0, 4'd2, 16'h0000);
        cdb(4'd2, 16'h8000); cyc();
        cyc();
        chk("byp_valid", {15'd0, issue_valid}, 16'd1);
        chk("byp_va", issue_va, 16'h8000);
        cyc();

        // Full station, ignored 5th dispatch, wake slot 1.
        for (int i = 0; i < DEPTH; i++) begin
            disp(4'b1000, 4'(i + 1), 1'b0, 4'(10 + i), 16'h0, 1'b1, 4'd0, 16'(i)); cyc();
        end
        chk("full_not_ready", {15'd0, disp_ready}, 16'd0);
        disp(4'b1000, 4'd15, 1'b1, 4'd0, 16'h0, 1'b1, 4'd0, 16'h0); cyc();
        cdb(4'd11, 16'h0abc); cyc();
        cyc();
        chk("full_slot1_rob", {12'd0, issue_rob}, 16'd2);
        chk("full_slot1_vt", issue_vt, 16'h0abc);
        chk("full_ready_again", {15'd0, disp_ready}, 16'd1);
        cdb(4'd10, 16'h1); cyc();
        cdb(4'd12, 16'h2); cyc();
        cdb(4'd13, 16'h3); cyc();
        repeat (3) cyc();

        // Flush beats dispatch, wakeup and issue in the same cycle.
        disp(4'b1001, 4'd1, 1'b0, 4'd4, 16'h0, 1'b1, 4'd0, 16'h0); cyc();
        disp(4'b1001, 4'd2, 1'b0, 4'd5, 16'h0, 1'b1, 4'd0, 16'h0); cyc();
        disp(4'b1001, 4'd3, 1'b0, 4'd6, 16'h0, 1'b1, 4'd0, 16'h0); cyc();
        cdb(4'd5, 16'h5555); cyc();
        flush = 1'b1; cdb(4'd4, 16'h4444);
        disp(4'b1000, 4'd8, 1'b1, 4'd0, 16'h0, 1'b1, 4'd0, 16'h0); cyc();
        chk("flush_issue_valid", {15'd0, issue_valid}, 16'd0);
        chk("flush_ready", {15'd0, disp_ready}, 16'd1);
        cdb(4'd6, 16'h6666); cyc();
        cyc();
        chk("flush_no_issue", {15'd0, issue_valid}, 16'd0);

        // Asynchronous reset mid-operation.
        disp(4'b1010, 4'd1, 1'b0, 4'd8, 16'h0, 1'b1, 4'd0, 16'h0); cyc();
        disp(4'b1010, 4'd2, 1'b0, 4'd9, 16'h0, 1'b1, 4'd0, 16'h0); cyc();
        disp(4'b1011, 4'd4, 1'b1, 4'd0, 16'h0777, 1'b1, 4'd0, 16'h0888); cyc();
        cyc();
        chk("pre_rst_valid", {15'd0, issue_valid}, 16'd1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("async_rst_valid", {15'd0, issue_valid}, 16'd0);
        chk("async_rst_vt", issue_vt, 16'd0);
        chk("async_rst_rob", {12'd0, issue_rob}, 16'd0);
        chk("async_rst_ready", {15'd0, disp_ready}, 16'd1);
        @(posedge clk); #1; reset = 1'b0;
        cdb(4'd8, 16'h1); cyc();
        cdb(4'd9, 16'h2); cyc();
        cyc();
        chk("post_rst_no_issue", {15'd0, issue_valid}, 16'd0);

        // Random traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            disp_valid  = ($urandom_range(0, 2) != 0);
            disp_opcode = 4'($urandom);
            disp_rob    = 4'($urandom);
            disp_t_rdy  = $urandom_range(0, 1) == 1;
            disp_a_rdy  = $urandom_range(0, 1) == 1;
            disp_t_tag  = 4'($urandom_range(0, 7));
            disp_a_tag  = 4'($urandom_range(0, 7));
            disp_t_val  = 16'($urandom);
            disp_a_val  = 16'($urandom);
            cdb_valid   = $urandom_range(0, 1) == 1;
            cdb_tag     = 4'($urandom_range(0, 7));
            cdb_value   = 16'($urandom);
            flush       = ($urandom_range(0, 24) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
